bk_serial_add_seq: RTL and testbench
====================================

Name: bk_serial_add_seq

Overview:
- Sequencer that adds or subtracts WIDTH-bit operands by time-multiplexing one 4-bit brent_kung_cin carry-in adder slice.
- Processes one nibble per cycle, LSB first, chaining the carry through a register.
- Upstream and downstream interfaces are valid/ready handshakes.
- Lets the tiny adder datapath serve wide operands without replicating slices.

Parameters:
- WIDTH, 16, operand/result width. Must be a multiple of 4 and >= 4. Local NSLICE = WIDTH/4.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  1 = subtract (A - B), 0 = add.
- in_cin  input  1  carry-in (add) or borrow-in (sub).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  result.
- out_cout  output  1  final carry out of the MSB slice.
- out_ovf  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN.

Behaviour:
- Asynchronous reset drives:
  - state = IDLE, slice counter = 0, carry register = 0.
  - out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0, busy = 0.
  - in_ready = 1 as soon as rst deasserts.
- States: IDLE, RUN, DONE.
- in_ready = (state == IDLE) | (state == DONE & out_ready).
- Accept = in_valid & in_ready. On accept:
  - A_reg <= in_a.
  - B_reg <= in_b XOR {WIDTH{in_sub}}.
  - carry <= in_cin XOR in_sub. Add computes A+B+cin; sub computes A-B-cin.
  - Latch a_msb = in_a[WIDTH-1] and b_msb = B_reg MSB after inversion.
  - Counter <= 0, state -> RUN.
- RUN, each cycle:
  - Slice gets A_reg[3:0], B_reg[3:0] and carry. Upper slice input bits are tied to 0.
  - Slice sum bits [3:0] are shifted into the top nibble of the sum register. After NSLICE shifts, nibble 0 sits in bits [3:0].
  - carry <= slice bit 4.
  - A_reg and B_reg shift right by 4. Counter increments.
- On the cycle where counter == NSLICE-1, the next state is DONE.
- DONE entry:
  - out_valid = 1.
  - out_sum = full sum register.
  - out_cout = final carry.
  - out_ovf = (a_msb == b_msb) & (out_sum[WIDTH-1] != a_msb).
- Latency: accept at cycle T gives out_valid high at T+NSLICE.
- DONE hold: while out_valid & !out_ready, out_sum, out_cout and out_ovf are held stable and no new request is accepted.
- Output handshake: out_valid & out_ready completes it.
  - With simultaneous in_valid, the new request is accepted in the same cycle, state -> RUN, out_valid -> 0.
  - Otherwise state -> IDLE.
  - Back-to-back throughput is one result per NSLICE+1 cycles at most.
- Outputs retain their last values after the handshake. Only out_valid qualifies them.
- in_a, in_b, in_sub and in_cin are ignored except on the accept cycle.
- Reset mid-RUN or in DONE aborts the operation: no result is produced and all outputs return to their reset values.
- WIDTH = 4 gives a single-cycle RUN. Counter width is max(1, clog2(NSLICE)).
- No combinational path from in_valid to any output. in_ready depends combinationally only on state and out_ready.

Test Plan:
- WIDTH=16, add 0x1234 + 0x0FCD, cin=0 -> out_sum=0x2201, cout=0, ovf=0. out_valid rises exactly 4 cycles after accept; busy high for 4 cycles.
- Carry chain: 0xFFFF + 0x0001, cin=0 -> 0x0000, cout=1, ovf=0. Separately, 0xFFFF + 0x0000, cin=1 -> 0x0000, cout=1.
- Subtract 0x0005 - 0x0007, sub=1, cin=0 -> 0xFFFE, cout=0 (borrow), ovf=0. Subtract 0x8000 - 0x0001 -> 0x7FFF, ovf=1, cout=1.
- Signed overflow on add: 0x7FFF + 0x0001 -> 0x8000, ovf=1, cout=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, out_sum and flags stable, in_ready=0. Then out_ready=1 together with in_valid=1 -> new request accepted in the same cycle and next result 4 cycles later.
- Reset mid-op: assert rst during RUN cycle 2 -> out_valid=0, busy=0, out_sum=0 immediately. After release, in_ready=1, and 0x00FF + 0x0001 -> 0x0100 correct. Repeat the add and reset cases at WIDTH=4: 0x9 + 0x8 -> 0x1, cout=1, ovf=1, 1-cycle latency.

Source files
------------

// File: rtl/bk_serial_add_seq.sv
// bk_serial_add_seq: serial add/sub sequencer reusing one 4-bit Brent-Kung carry-in slice, LSB nibble first.
module bk_serial_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);
  localparam int NSLICE = WIDTH / 4;
  localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg, sum_nx;
  logic [CW-1:0] cnt;
  logic carry, a_msb, b_msb, accept, last;
  logic [3:0] g, p, c, ss;
  logic g10, p10, g32, p32, g20, p20, g30, p30, sc;
  // Brent-Kung prefix tree over the low nibble of the operand shift registers
  assign g = a_reg[3:0] & b_reg[3:0];
  assign p = a_reg[3:0] ^ b_reg[3:0];
  assign g10 = g[1] | (p[1] & g[0]);
  assign p10 = p[1] & p[0];
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];
  assign g20 = g[2] | (p[2] & g10);
  assign p20 = p[2] & p10;
  assign g30 = g32 | (p32 & g10);
  assign p30 = p32 & p10;
  assign c = {g20 | (p20 & carry), g10 | (p10 & carry), g[0] | (p[0] & carry), carry};
  assign ss = p ^ c;
  assign sc = g30 | (p30 & carry);
  assign sum_nx = WIDTH'({ss, sum_reg} >> 4);
  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept = in_valid & in_ready;
  assign last = (state == RUN) && (cnt == CW'(NSLICE - 1));
  assign busy = state == RUN;
  always_comb begin
    state_nx = state;
    state_nx = accept ? RUN : last ? DONE : (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      sum_reg <= '0;
      cnt <= '0;
      carry <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      out_valid <= 1'b0;
      out_sum <= '0;
      out_cout <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      if (accept) begin
        a_reg <= in_a;
        b_reg <= in_b ^ {WIDTH{in_sub}};
        carry <= in_cin ^ in_sub;
        a_msb <= in_a[WIDTH-1];
        b_msb <= in_b[WIDTH-1] ^ in_sub;
        cnt <= '0;
      end else if (state == RUN) begin
        a_reg <= a_reg >> 4;
        b_reg <= b_reg >> 4;
        sum_reg <= sum_nx;
        carry <= sc;
        cnt <= cnt + 1'b1;
      end
      // the final slice's sum bit 3 becomes the result MSB
      if (last) begin
        out_valid <= 1'b1;
        out_sum <= sum_nx;
        out_cout <= sc;
        out_ovf <= (a_msb == b_msb) && (ss[3] != a_msb);
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_bk_serial_add_seq.sv
// tb_bk_serial_add_seq: scoreboard bench for WIDTH=16 and WIDTH=4 instances with directed vectors.
module tb_bk_serial_add_seq;
  typedef struct {
    logic [15:0] s;
    logic c;
    logic o;
    int cyc;
  } exp_t;
  logic clk = 0, rst = 1;
  logic iv16 = 0, or16 = 1, sub16 = 0, cin16 = 0, ir16, ov16, co16, of16, bz16;
  logic [15:0] a16 = 0, b16 = 0, s16;
  logic iv4 = 0, or4 = 1, sub4 = 0, cin4 = 0, ir4, ov4, co4, of4, bz4;
  logic [3:0] a4 = 0, b4 = 0, s4;
  int n_vec = 0, n_err = 0, cyc = 0;
  logic pv16 = 0, pv4 = 0;
  exp_t q16[$], q4[$];
  exp_t e16, e4;
  bk_serial_add_seq #(.WIDTH(16)) d16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
    .in_sub(sub16), .in_cin(cin16), .out_valid(ov16), .out_ready(or16), .out_sum(s16),
    .out_cout(co16), .out_ovf(of16), .busy(bz16)
  );
  bk_serial_add_seq #(.WIDTH(4)) d4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
    .in_sub(sub4), .in_cin(cin4), .out_valid(ov4), .out_ready(or4), .out_sum(s4),
    .out_cout(co4), .out_ovf(of4), .busy(bz4)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s", nm);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // caller is positioned just after a rising edge; returns just after the accept edge
  task automatic issue(input bit w4, input bit push, input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic cin, input logic [15:0] es, input logic ec,
                       input logic eo);
    int k = 0;
    if (w4) begin a4 = a[3:0]; b4 = b[3:0]; sub4 = sub; cin4 = cin; iv4 = 1; end
    else begin a16 = a; b16 = b; sub16 = sub; cin16 = cin; iv16 = 1; end
    forever begin
      @(negedge clk);
      if ((w4 ? ir4 : ir16) || k == 100) break;
      k++;
    end
    @(posedge clk);
    #1;
    iv4 = 0;
    iv16 = 0;
    a16 = 16'hDEAD; b16 = 16'hBEEF; a4 = 4'hA; b4 = 4'h5; sub4 = ~sub4; sub16 = ~sub16;
    if (k == 100) fail(w4 ? "accept_timeout4" : "accept_timeout16");
    else if (push) begin
      if (w4) q4.push_back('{es, ec, eo, cyc + 1});
      else q16.push_back('{es, ec, eo, cyc + 4});
    end
  endtask
  task automatic drain;
    int k = 0;
    while ((q16.size() != 0 || q4.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k == 200) fail("drain_timeout");
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (ov16 && !pv16) begin
        if (q16.size() == 0) fail("spurious16");
        else chk("lat16", cyc, q16[0].cyc);
      end
      if (ov16 && or16 && q16.size() != 0) begin
        e16 = q16.pop_front();
        chk("sum16", s16, e16.s);
        chk("cout16", co16, e16.c);
        chk("ovf16", of16, e16.o);
      end
      if (ov4 && !pv4) begin
        if (q4.size() == 0) fail("spurious4");
        else chk("lat4", cyc, q4[0].cyc);
      end
      if (ov4 && or4 && q4.size() != 0) begin
        e4 = q4.pop_front();
        chk("sum4", s4, e4.s);
        chk("cout4", co4, e4.c);
        chk("ovf4", of4, e4.o);
      end
    end
    pv16 <= ov16 & ~rst;
    pv4 <= ov4 & ~rst;
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid16", ov16, 0);
    chk("rst_busy16", bz16, 0);
    chk("rst_sum16", s16, 0);
    chk("rst_flags16", {co16, of16}, 0);
    chk("rst_valid4", ov4, 0);
    step;
    rst = 0;
    #1;
    chk("ready16", ir16, 1);
    chk("ready4", ir4, 1);
    issue(0, 1, 16'h1234, 16'h0FCD, 0, 0, 16'h2201, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy_run16", bz16, 1);
    end
    @(negedge clk);
    chk("busy_done16", bz16, 0);
    step;
    issue(0, 1, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
    issue(0, 1, 16'hFFFF, 16'h0000, 0, 1, 16'h0000, 1, 0);
    issue(0, 1, 16'h0005, 16'h0007, 1, 0, 16'hFFFE, 0, 0);
    issue(0, 1, 16'h8000, 16'h0001, 1, 0, 16'h7FFF, 1, 1);
    issue(0, 1, 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
    drain;
    step;
    or16 = 0;
    issue(0, 1, 16'h1111, 16'h2222, 0, 0, 16'h3333, 0, 0);
    for (int k = 0; k < 100 && !ov16; k++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", ov16, 1);
      chk("hold_sum", s16, 16'h3333);
      chk("hold_flags", {co16, of16}, 0);
      chk("hold_ready", ir16, 0);
      @(negedge clk);
    end
    step;
    or16 = 1;
    issue(0, 1, 16'h4000, 16'h4000, 0, 0, 16'h8000, 0, 1);
    drain;
    step;
    issue(0, 0, 16'h1234, 16'h1111, 0, 0, 0, 0, 0);
    step;
    rst = 1;
    #1;
    chk("abort_valid16", ov16, 0);
    chk("abort_busy16", bz16, 0);
    chk("abort_sum16", s16, 0);
    chk("abort_flags16", {co16, of16}, 0);
    step;
    step;
    rst = 0;
    #1;
    chk("abort_ready16", ir16, 1);
    issue(0, 1, 16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0);
    drain;
    step;
    issue(1, 1, 16'h9, 16'h8, 0, 0, 16'h1, 1, 1);
    issue(1, 1, 16'h7, 16'h1, 0, 0, 16'h8, 0, 1);
    issue(1, 1, 16'h2, 16'h3, 1, 0, 16'hF, 0, 0);
    issue(1, 1, 16'h3, 16'h4, 0, 0, 16'h7, 0, 0);
    drain;
    step;
    issue(1, 0, 16'h6, 16'h6, 0, 0, 0, 0, 0);
    rst = 1;
    #1;
    chk("abort_valid4", ov4, 0);
    chk("abort_busy4", bz4, 0);
    chk("abort_sum4", s4, 0);
    step;
    rst = 0;
    #1;
    chk("abort_ready4", ir4, 1);
    issue(1, 1, 16'h9, 16'h8, 0, 0, 16'h1, 1, 1);
    drain;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
